// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a latched pattern out MSB-first, repeated in_reps+1 times with idle gaps
module serial_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [REP_W-1:0] in_reps,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] pat, pat_n, sh, sh_n, aligned;
  logic [LEN_W-1:0] len, len_n, bit_cnt, bit_n, eff_len;
  logic [REP_W-1:0] rep_cnt, rep_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic out_n, ov_n, busy_n, done_n;
  assign in_ready = state == IDLE;
  assign eff_len = in_len > LEN_W'(WIDTH) ? LEN_W'(WIDTH) : in_len;
  // patterns are stored MSB-aligned so every bit leaves from the top of the shifter
  assign aligned = in_data << (LEN_W'(WIDTH) - eff_len);
  always_comb begin
    state_n = state;
    pat_n = pat;
    sh_n = sh;
    len_n = len;
    bit_n = bit_cnt;
    rep_n = rep_cnt;
    gap_n = gap_cnt;
    out_n = 1'b0;
    ov_n = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: if (in_valid && !abort) begin
        pat_n = aligned;
        len_n = eff_len;
        rep_n = in_reps;
        if (eff_len == '0) done_n = 1'b1;
        else begin
          state_n = SHIFT;
          out_n = aligned[WIDTH-1];
          sh_n = aligned << 1;
          bit_n = eff_len - 1'b1;
          ov_n = 1'b1;
          busy_n = 1'b1;
        end
      end
      SHIFT: if (bit_cnt != '0) begin
        out_n = sh[WIDTH-1];
        sh_n = sh << 1;
        bit_n = bit_cnt - 1'b1;
        ov_n = 1'b1;
        busy_n = 1'b1;
      end else if (rep_cnt != '0) begin
        rep_n = rep_cnt - 1'b1;
        busy_n = 1'b1;
        if (GAP_CYCLES > 0) begin
          state_n = GAP;
          gap_n = GW'(GAP_CYCLES - 1);
        end else begin
          out_n = pat[WIDTH-1];
          sh_n = pat << 1;
          bit_n = len - 1'b1;
          ov_n = 1'b1;
        end
      end else begin
        state_n = IDLE;
        done_n = 1'b1;
      end
      GAP: begin
        busy_n = 1'b1;
        if (gap_cnt != '0) gap_n = gap_cnt - 1'b1;
        else begin
          state_n = SHIFT;
          out_n = pat[WIDTH-1];
          sh_n = pat << 1;
          bit_n = len - 1'b1;
          ov_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      bit_n = '0;
      rep_n = '0;
      gap_n = '0;
      out_n = 1'b0;
      ov_n = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pat <= '0;
      sh <= '0;
      len <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      out <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      pat <= pat_n;
      sh <= sh_n;
      len <= len_n;
      bit_cnt <= bit_n;
      rep_cnt <= rep_n;
      out <= out_n;
      out_valid <= ov_n;
      busy <= busy_n;
      done <= done_n;
    end
  generate
    if (GAP_CYCLES > 0) begin : g_gap
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) gap_cnt <= '0;
        else gap_cnt <= gap_n;
    end else begin : g_nogap
      assign gap_cnt = '0;
    end
  endgenerate
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed checks of serial_pattern_tx bit streams, gaps, abort and reset
module tb_serial_pattern_tx;
  localparam int GAP = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, abort = 0;
  logic in_ready, out, out_valid, busy, done;
  logic [7:0] in_data = '0;
  logic [3:0] in_len = '0, in_reps = '0;
  int checks = 0, errors = 0;

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .in_reps(in_reps), .abort(abort),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_rdy"}, in_ready, 1);
  endtask

  // accept at cycle k, then walk every following cycle through the expected stream up to done
  task automatic run(input string tag, input logic [7:0] d, input logic [3:0] l, input logic [3:0] r,
                     input bit hold, input logic [7:0] nd, input logic [3:0] nl, input logic [3:0] nr);
    int e;
    e = l > 8 ? 8 : int'(l);
    in_data = d; in_len = l; in_reps = r; in_valid = 1;
    chk({tag, "_rdy_k"}, in_ready, 1);
    tick;
    if (hold) begin
      in_data = nd; in_len = nl; in_reps = nr;
    end else in_valid = 0;
    for (int rep = 0; rep <= int'(r); rep++) begin
      for (int i = e - 1; i >= 0; i--) begin
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_bit"}, out, d[i]);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done_early"}, done, 0);
        chk({tag, "_rdy_busy"}, in_ready, 0);
        tick;
      end
      if (rep < int'(r))
        for (int g = 0; g < GAP; g++) begin
          chk({tag, "_gap_ov"}, out_valid, 0);
          chk({tag, "_gap_busy"}, busy, 1);
          chk({tag, "_gap_done"}, done, 0);
          tick;
        end
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_ov"}, out_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_out"}, out, 0);
    chk({tag, "_done_rdy"}, in_ready, 1);
  endtask

  initial begin
    #3;
    idle_chk("rst");
    tick;
    rst_n = 1;
    tick;
    tick;
    idle_chk("post_rst");
    run("single", 8'h06, 3, 0, 0, 0, 0, 0);
    tick;
    chk("single_done_once", done, 0);
    run("gap", 8'hA5, 8, 1, 0, 0, 0, 0);
    tick;
    run("len0", 8'h5A, 0, 0, 0, 0, 0, 0);
    tick;
    run("clamp", 8'h96, 12, 0, 0, 0, 0, 0);
    tick;
    // abort during the third bit
    in_data = 8'hFF; in_len = 8; in_reps = 0; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    tick;
    chk("abort_bit3_ov", out_valid, 1);
    abort = 1;
    tick;
    abort = 0;
    idle_chk("abort");
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_done", done, 0);
      chk("abort_no_ov", out_valid, 0);
      tick;
    end
    abort = 1; in_valid = 1; in_len = 4;
    tick;
    abort = 0; in_valid = 0;
    idle_chk("abort_idle");
    tick;
    idle_chk("abort_idle2");
    // held valid: second request ignored while busy, then taken in the done cycle
    run("held1", 8'h06, 3, 0, 1, 8'hC3, 4, 0);
    run("held2", 8'hC3, 4, 0, 0, 0, 0, 0);
    tick;
    // async reset mid-transfer
    in_data = 8'hFF; in_len = 8; in_reps = 2; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    chk("areset_pre_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    idle_chk("areset");
    tick;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      idle_chk("areset_after");
      tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial pattern transmitter. Accepts a parallel bit pattern, a length and a repeat count over a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, on a single-bit line with a qualifying valid strobe.
- Feeds stimulus into the serial sequence-detecting FSMs in the same design. Signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, maximum pattern length in bits; width of in_data.
- LEN_W, 4, width of in_len; must satisfy 2**LEN_W > WIDTH.
- REP_W, 4, width of in_reps.
- GAP_CYCLES, 2, idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  pattern; bits [in_len-1:0] are sent, MSB first.
- in_len  in  LEN_W  number of bits to send per repetition.
- in_reps  in  REP_W  extra repetitions; total sends = in_reps+1.
- abort  in  1  synchronous cancel.
- out  out  1  serial bit.
- out_valid  out  1  out carries a pattern bit this cycle.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse: transfer completed normally.

Behaviour:
- Clock and reset: clk is the clock; rst_n is the reset, asynchronous, active-low.
- Reset values: state=IDLE, out=0, out_valid=0, busy=0, done=0. in_ready=1 while in reset.
- State machine: IDLE, SHIFT, GAP.
- Output timing: in_ready = (state==IDLE), combinational. All other outputs are registered.
- Accept: the cycle k where in_valid && in_ready && !abort.
  - Latch in_data, eff_len and in_reps.
  - eff_len = min(in_len, WIDTH), i.e. in_len > WIDTH is clamped to WIDTH.
- IDLE -> SHIFT on accept with eff_len>0.
  - Cycles k+1 .. k+eff_len: out = data[eff_len-1] down to data[0], out_valid=1, busy=1.
- eff_len==0: no bits are sent. State stays IDLE and done=1 in cycle k+1.
- After the last bit of a repetition, if repetitions remain:
  - GAP_CYCLES>0: go to GAP for exactly GAP_CYCLES cycles (out=0, out_valid=0, busy=1), then SHIFT again.
  - GAP_CYCLES==0: the next repetition's first bit follows directly in the next cycle.
- After the last bit of the last repetition: next cycle state=IDLE, out=0, out_valid=0, busy=0, done=1 (exactly one cycle).
  - in_ready=1 in the done cycle, so a new request may be accepted in that same cycle.
- Total duration for one request: out_valid is asserted for eff_len*(in_reps+1) cycles. done occurs at cycle k + eff_len*(in_reps+1) + GAP_CYCLES*in_reps + 1.
- in_valid while busy: ignored; no back-pressure side effects. Inputs are sampled only at accept.
- abort (highest priority, any state): next cycle state=IDLE, out=0, out_valid=0, busy=0, done=0.
  - All counters clear.
  - abort in IDLE with in_valid=1: no accept.
- Async reset mid-transfer: outputs take reset values immediately. No done pulse.
- Counters:
  - bit_cnt: LEN_W bits.
  - gap_cnt: sized for GAP_CYCLES; omitted when GAP_CYCLES==0.
  - rep_cnt: REP_W bits, counts down.
  - No wrap: rep_cnt==0 at end of a repetition terminates the transfer.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> out=0, out_valid=0, busy=0, done=0, in_ready=1 immediately. After release, state holds IDLE with in_valid=0.
- Single send: in_data=8'h06, in_len=3, in_reps=0, accept at k -> out=1,1,0 with out_valid=1 at k+1..k+3; done=1 at k+4 only; busy high k+1..k+3.
- Repeat with gap: in_data=8'hA5, in_len=8, in_reps=1, GAP_CYCLES=2 -> bits 1,0,1,0,0,1,0,1 at k+1..k+8; out_valid=0 at k+9..k+10; same bits at k+11..k+18; done at k+19.
- Edge lengths: in_len=0 -> no out_valid, done at k+1. in_len=12 (WIDTH=8) -> 8 bits sent, MSB data[7] first.
- Abort: start in_data=8'hFF, in_len=8; abort after the 3rd bit -> out_valid=0 and busy=0 next cycle, no done pulse, in_ready=1. Abort asserted in IDLE with in_valid=1 -> no accept.
- Back-to-back and held valid: hold in_valid=1 continuously with two requests.
  - While busy, the new request is not accepted.
  - The second request is accepted in the done cycle of the first; its first bit follows on the next cycle with no dead cycle.
